// File: rtl/imm_alu_seq_if.sv
// Handshake/bus bundle between the control unit's byte-fetch path and imm_alu_seq.
// The master side issues operations and streams immediate bytes; the slave side is the unit.
interface imm_alu_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] acc_in;
    logic [7:0]            imm_data;
    logic                  imm_valid;
    logic                  imm_ready;
    logic                  busy;
    logic [DATA_WIDTH-1:0] result;
    logic                  result_valid;
    logic                  acc_we;
    logic                  flag_zero;
    logic                  flag_negative;
    logic                  flag_carry;
    logic                  illegal_op;

    modport master (
        output start, op, acc_in, imm_data, imm_valid,
        input  imm_ready, busy, result, result_valid, acc_we,
               flag_zero, flag_negative, flag_carry, illegal_op
    );

    modport slave (
        input  start, op, acc_in, imm_data, imm_valid,
        output imm_ready, busy, result, result_valid, acc_we,
               flag_zero, flag_negative, flag_carry, illegal_op
    );
endinterface

// File: rtl/imm_alu_seq.sv
// Multi-cycle immediate-operand ALU: fetches a DATA_WIDTH immediate LSB-first over a byte
// handshake, executes against the captured accumulator, then writes back result and Z/N/C.
module imm_alu_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    imm_alu_seq_if.slave bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_width
            $error("imm_alu_seq: DATA_WIDTH must be a multiple of 8 in 8..32");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    state_t                state, state_nxt;
    logic [2:0]            op_q;
    logic [DATA_WIDTH-1:0] acc_q, imm_q, result_q;
    logic [CNT_W-1:0]      byte_cnt;
    logic                  z_q, n_q, c_q;
    logic                  xfer, last_byte;
    logic [DATA_WIDTH:0]   sum, diff;
    logic [DATA_WIDTH-1:0] alu_val;
    logic                  alu_c;

    assign xfer      = (state == FETCH) && bus.imm_valid;
    assign last_byte = (byte_cnt == CNT_W'(NUM_BYTES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.op == OP_ILL) ? WB : FETCH;
            FETCH:   if (xfer && last_byte) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Extra top bit carries ADD carry-out; for SUB/CMP it is the unsigned borrow.
    assign sum  = {1'b0, acc_q} + {1'b0, imm_q};
    assign diff = {1'b0, acc_q} - {1'b0, imm_q};

    always_comb begin
        alu_val = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_AND:  alu_val = acc_q & imm_q;
            OP_OR:   alu_val = acc_q | imm_q;
            OP_XOR:  alu_val = acc_q ^ imm_q;
            OP_ADD:  begin alu_val = sum[DATA_WIDTH-1:0];  alu_c = sum[DATA_WIDTH];  end
            OP_SUB,
            OP_CMP:  begin alu_val = diff[DATA_WIDTH-1:0]; alu_c = diff[DATA_WIDTH]; end
            OP_PASS: begin alu_val = imm_q;                alu_c = c_q;              end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            imm_q    <= '0;
            byte_cnt <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.start) begin
                    op_q     <= bus.op;
                    acc_q    <= bus.acc_in;
                    byte_cnt <= '0;
                end
                FETCH: if (xfer) begin
                    for (int i = 0; i < NUM_BYTES; i++)
                        if (byte_cnt == CNT_W'(i)) imm_q[i*8 +: 8] <= bus.imm_data;
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
                EXEC: if (op_q != OP_ILL) begin
                    result_q <= alu_val;
                    z_q      <= (alu_val == '0);
                    n_q      <= alu_val[DATA_WIDTH-1];
                    c_q      <= alu_c;
                end
                default: ;
            endcase
        end
    end

    assign bus.imm_ready     = (state == FETCH);
    assign bus.busy          = (state != IDLE);
    assign bus.result_valid  = (state == WB);
    assign bus.acc_we        = (state == WB) && (op_q != OP_CMP) && (op_q != OP_ILL);
    assign bus.illegal_op    = (state == WB) && (op_q == OP_ILL);
    assign bus.result        = result_q;
    assign bus.flag_zero     = z_q;
    assign bus.flag_negative = n_q;
    assign bus.flag_carry    = c_q;
endmodule
